// File: rtl/vote_pkg.sv
// Shared definitions for the majority-voter self-test sweep: state encoding,
// vector count and the golden bitwise 2-of-3 majority function.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_VEC = 8;

    // Operands up to 32 bits wide; callers zero-extend and truncate the result.
    function automatic logic [31:0] maj3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/vote_vec_gen.sv
// Combinational operand encoder: turns a 3-bit sweep index into the three
// voter operands, either zero-extended bits or bits replicated across WID.
module vote_vec_gen #(
    parameter int WID  = 5,
    parameter int FILL = 0
) (
    input  logic [2:0]     i_vecIdx,
    output logic [WID-1:0] o_op0,
    output logic [WID-1:0] o_op1,
    output logic [WID-1:0] o_op2
);

    always_comb begin
        if (FILL != 0) begin
            o_op0 = {WID{i_vecIdx[2]}};
            o_op1 = {WID{i_vecIdx[1]}};
            o_op2 = {WID{i_vecIdx[0]}};
        end else begin
            o_op0 = WID'(i_vecIdx[2]);
            o_op1 = WID'(i_vecIdx[1]);
            o_op2 = WID'(i_vecIdx[0]);
        end
    end

endmodule

// File: rtl/vote_sweep_checker.sv
// On-chip exhaustive sweep driver and checker for a WID-bit 2-of-3 voter:
// drives each of the 8 operand vectors for HOLD cycles and samples OUT once.
module vote_sweep_checker
    import vote_pkg::*;
#(
    parameter int WID    = 5,
    parameter int HOLD   = 10,
    parameter int SETTLE = 1,
    parameter int FILL   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [WID-1:0] I0,
    output logic [WID-1:0] I1,
    output logic [WID-1:0] I2,
    input  logic [WID-1:0] OUT,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [3:0]     err_cnt,
    output logic [2:0]     first_fail,
    output logic [WID-1:0] fail_bits
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t         r_state;
    logic [2:0]     r_vecIdx;
    logic [HW-1:0]  r_holdCnt;
    logic [WID-1:0] r_I0, r_I1, r_I2;
    logic           r_busy, r_done, r_pass;
    logic [3:0]     r_errCnt;
    logic [2:0]     r_firstFail;
    logic [WID-1:0] r_failBits;

    logic [2:0]     w_genIdx;
    logic [WID-1:0] w_op0, w_op1, w_op2;
    logic [31:0]    w_maj32;
    logic [WID-1:0] w_expected;
    logic           w_sample, w_mismatch, w_lastCycle, w_lastVec;
    logic [3:0]     w_errNext;

    // Outside RUN the encoder presents vector 0, ready to load on start.
    assign w_genIdx = (r_state == ST_RUN) ? 3'(r_vecIdx + 3'd1) : 3'd0;

    vote_vec_gen #(
        .WID  (WID),
        .FILL (FILL)
    ) u_vecGen (
        .i_vecIdx (w_genIdx),
        .o_op0    (w_op0),
        .o_op1    (w_op1),
        .o_op2    (w_op2)
    );

    assign w_maj32     = maj3(32'(r_I0), 32'(r_I1), 32'(r_I2));
    assign w_expected  = w_maj32[WID-1:0];
    assign w_sample    = (r_state == ST_RUN) && (r_holdCnt == HW'(SETTLE));
    assign w_mismatch  = w_sample && (OUT != w_expected);
    assign w_errNext   = r_errCnt + {3'd0, w_mismatch};
    assign w_lastCycle = (r_holdCnt == HW'(HOLD - 1));
    assign w_lastVec   = (r_vecIdx == 3'(NUM_VEC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_vecIdx    <= '0;
            r_holdCnt   <= '0;
            r_I0        <= '0;
            r_I1        <= '0;
            r_I2        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_errCnt    <= '0;
            r_firstFail <= '0;
            r_failBits  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_vecIdx    <= '0;
                        r_holdCnt   <= '0;
                        r_I0        <= w_op0;
                        r_I1        <= w_op1;
                        r_I2        <= w_op2;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_errCnt    <= '0;
                        r_firstFail <= '0;
                        r_failBits  <= '0;
                    end
                end
                ST_RUN: begin
                    r_holdCnt <= r_holdCnt + HW'(1);
                    if (w_mismatch) begin
                        r_errCnt <= w_errNext;
                        if (r_errCnt == 4'd0) begin
                            r_firstFail <= r_vecIdx;
                            r_failBits  <= OUT ^ w_expected;
                        end
                    end
                    if (w_lastCycle) begin
                        r_holdCnt <= '0;
                        if (!w_lastVec) begin
                            r_vecIdx <= 3'(r_vecIdx + 3'd1);
                            r_I0     <= w_op0;
                            r_I1     <= w_op1;
                            r_I2     <= w_op2;
                        end else begin
                            // w_errNext covers a sample landing on the final cycle.
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_errNext == 4'd0);
                            r_I0    <= '0;
                            r_I1    <= '0;
                            r_I2    <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign I0         = r_I0;
    assign I1         = r_I1;
    assign I2         = r_I2;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_errCnt;
    assign first_fail = r_firstFail;
    assign fail_bits  = r_failBits;

endmodule
